// File: rtl/scr1_cg_pkg.sv
// Shared types and helpers for the SCR1 clock-gating controller.
// Holds the per-channel FSM state encoding and the wake-counter width helper.
package scr1_cg_pkg;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StCount = 2'd1,
        StGated = 2'd2,
        StWake  = 2'd3
    } type_scr1_cg_state_e;

    localparam type_scr1_cg_state_e CgRstState = StRun;

    // Ceiling log2 with a floor of one bit, so every counter is at least 1 bit wide.
    function automatic int unsigned cg_clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((64'd1 << width) < 64'(value)) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/scr1_cg_cell.sv
// Latch-based clock gate: enable is captured while clk is low and ANDed with clk.
// Swap this module for the technology ICG cell in synthesis.
module scr1_cg_cell (
    input  logic clk,
    input  logic clk_en,
    input  logic test_mode,
    output logic clk_out
);

    logic en_latch;

    always_latch begin
        if (!clk) begin
            en_latch <= clk_en | test_mode;
        end
    end

    assign clk_out = en_latch & clk;

endmodule

// File: rtl/scr1_cg_ctrl.sv
// Multi-channel clock-gating controller with per-channel idle hysteresis.
// Each channel gates after idle_thresh+1 idle cycles and holds off ready for WAKE_DLY on wake.
module scr1_cg_ctrl
    import scr1_cg_pkg::*;
#(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned IDLE_CNT_W = 4,
    parameter int unsigned WAKE_DLY   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  test_mode,
    input  logic [CHANNELS-1:0]   ch_busy,
    input  logic [CHANNELS-1:0]   ch_wake_req,
    input  logic [CHANNELS-1:0]   force_on,
    input  logic [IDLE_CNT_W-1:0] idle_thresh,
    output logic [CHANNELS-1:0]   clk_out,
    output logic [CHANNELS-1:0]   ch_gated,
    output logic [CHANNELS-1:0]   ch_ready
);

    localparam int unsigned WakeCntW = cg_clog2(WAKE_DLY + 1);

    if (WAKE_DLY == 0) begin : gen_bad_wake_dly
        $error("scr1_cg_ctrl: WAKE_DLY must be at least 1");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : gen_ch
        type_scr1_cg_state_e   state_q, state_d;
        logic [IDLE_CNT_W-1:0] cnt_q, cnt_d;
        logic [WakeCntW-1:0]   wcnt_q, wcnt_d;
        logic                  act;
        logic                  clk_en;

        assign act = ch_busy[i] | ch_wake_req[i] | force_on[i];

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            wcnt_d  = wcnt_q;
            unique case (state_q)
                StRun: begin
                    if (!act) begin
                        state_d = StCount;
                        cnt_d   = '0;
                    end
                end
                StCount: begin
                    // >= lets a threshold lowered mid-count gate on the next cycle
                    if (act) begin
                        state_d = StRun;
                    end else if (cnt_q >= idle_thresh) begin
                        state_d = StGated;
                    end else begin
                        cnt_d = cnt_q + IDLE_CNT_W'(1);
                    end
                end
                StGated: begin
                    if (act) begin
                        state_d = StWake;
                        wcnt_d  = WakeCntW'(1);
                    end
                end
                StWake: begin
                    // Wake always completes; activity is not sampled here
                    if (wcnt_q == WakeCntW'(WAKE_DLY)) begin
                        state_d = StRun;
                    end else begin
                        wcnt_d = wcnt_q + WakeCntW'(1);
                    end
                end
                default: begin
                    state_d = CgRstState;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= CgRstState;
                cnt_q   <= '0;
                wcnt_q  <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                wcnt_q  <= wcnt_d;
            end
        end

        // Enable comes only from registered state, so no input reaches the gate directly
        assign clk_en      = (state_q != StGated);
        assign ch_gated[i] = (state_q == StGated);
        assign ch_ready[i] = (state_q == StRun) || (state_q == StCount);

        scr1_cg_cell u_cg_cell (
            .clk       (clk),
            .clk_en    (clk_en),
            .test_mode (test_mode),
            .clk_out   (clk_out[i])
        );
    end

endmodule

// File: tb/tb_scr1_cg_ctrl.sv
// Directed bench for scr1_cg_ctrl with CHANNELS=4, IDLE_CNT_W=4, WAKE_DLY=2.
// Outputs are sampled 2 time units after each rising edge, while clk is still high.
module tb_scr1_cg_ctrl;

    logic       clk;
    logic       rst_n;
    logic       test_mode;
    logic [3:0] ch_busy;
    logic [3:0] ch_wake_req;
    logic [3:0] force_on;
    logic [3:0] idle_thresh;
    logic [3:0] clk_out;
    logic [3:0] ch_gated;
    logic [3:0] ch_ready;

    int checks = 0;
    int errors = 0;

    scr1_cg_ctrl #(
        .CHANNELS   (4),
        .IDLE_CNT_W (4),
        .WAKE_DLY   (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .test_mode   (test_mode),
        .ch_busy     (ch_busy),
        .ch_wake_req (ch_wake_req),
        .force_on    (force_on),
        .idle_thresh (idle_thresh),
        .clk_out     (clk_out),
        .ch_gated    (ch_gated),
        .ch_ready    (ch_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Hold reset for two edges, then release just after an edge; next edge is cycle 1.
    task automatic do_reset(input logic [3:0] thresh);
        rst_n       = 1'b0;
        test_mode   = 1'b0;
        ch_busy     = '0;
        ch_wake_req = '0;
        force_on    = '0;
        idle_thresh = thresh;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        test_mode   = 1'b0;
        ch_busy     = '0;
        ch_wake_req = '0;
        force_on    = '0;
        idle_thresh = 4'd3;

        // Reset values
        tick();
        check("rst_ready", ch_ready, 4'b1111);
        check("rst_gated", ch_gated, 4'b0000);
        check("rst_clk_out", clk_out, 4'b1111);

        // Idle gating with threshold 3: GATED at cycle 5, pulse 6 suppressed
        do_reset(4'd3);
        for (int c = 1; c <= 6; c++) begin
            tick();
            check($sformatf("idle_gated_c%0d", c), ch_gated, (c >= 5) ? 4'b1111 : 4'b0000);
            check($sformatf("idle_ready_c%0d", c), ch_ready, (c >= 5) ? 4'b0000 : 4'b1111);
            check($sformatf("idle_clk_c%0d", c), clk_out, (c >= 6) ? 4'b0000 : 4'b1111);
        end

        // Wake channel 2 with a one-cycle busy pulse
        ch_busy = 4'b0100;
        tick();
        ch_busy = 4'b0000;
        check("wake_t_clk", clk_out, 4'b0000);
        check("wake_t_gated", ch_gated, 4'b1011);
        check("wake_t_ready", ch_ready, 4'b0000);
        tick();
        check("wake_t1_clk", clk_out, 4'b0100);
        check("wake_t1_ready", ch_ready, 4'b0000);
        tick();
        check("wake_t2_clk", clk_out, 4'b0100);
        check("wake_t2_ready", ch_ready, 4'b0100);
        check("wake_t2_gated", ch_gated, 4'b1011);

        // Threshold 0: gate after one COUNT cycle; act in that cycle returns ch1 to RUN
        do_reset(4'd0);
        tick();
        check("thr0_c1_gated", ch_gated, 4'b0000);
        ch_busy = 4'b0010;
        tick();
        ch_busy = 4'b0000;
        check("thr0_c2_gated", ch_gated, 4'b1101);
        check("thr0_c2_ready", ch_ready, 4'b0010);
        check("thr0_c2_clk", clk_out, 4'b1111);
        tick();
        check("thr0_c3_clk", clk_out, 4'b0010);
        check("thr0_c3_gated", ch_gated, 4'b1101);
        tick();
        check("thr0_c4_clk", clk_out, 4'b0010);
        check("thr0_c4_gated", ch_gated, 4'b1111);
        tick();
        check("thr0_c5_clk", clk_out, 4'b0000);

        // force_on[0] keeps channel 0 running for 50 cycles
        do_reset(4'd3);
        force_on = 4'b0001;
        for (int c = 1; c <= 50; c++) begin
            tick();
            check($sformatf("force_ready0_c%0d", c), {3'b000, ch_ready[0]}, 4'b0001);
        end
        check("force_gated", ch_gated, 4'b1110);
        check("force_clk", clk_out, 4'b0001);
        check("force_ready", ch_ready, 4'b0001);
        force_on = 4'b0000;
        repeat (4) tick();
        check("unforce_c4_gated", ch_gated, 4'b1110);
        tick();
        check("unforce_c5_gated", ch_gated, 4'b1111);
        tick();
        check("unforce_c6_clk", clk_out, 4'b0000);

        // test_mode overrides gating from the next pulse; status untouched
        test_mode = 1'b1;
        tick();
        check("tm_clk", clk_out, 4'b1111);
        check("tm_gated", ch_gated, 4'b1111);
        check("tm_ready", ch_ready, 4'b0000);
        test_mode = 1'b0;
        tick();
        check("tm_off_clk", clk_out, 4'b0000);

        // Reset asserted with channel 0 in WAKE and others GATED
        ch_wake_req = 4'b0001;
        tick();
        ch_wake_req = 4'b0000;
        check("pre_rst_gated", ch_gated, 4'b1110);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", ch_ready, 4'b1111);
        check("mid_rst_gated", ch_gated, 4'b0000);
        tick();
        check("mid_rst_clk", clk_out, 4'b1111);
        rst_n = 1'b1;
        tick();
        check("post_rst_clk", clk_out, 4'b1111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scr1_cg_ctrl.md
# scr1_cg_ctrl

Multi-channel clock-gating controller for the SCR1 core clock tree. It gives each of `CHANNELS` downstream domains its own gated clock, controlled by a per-channel idle-hysteresis FSM. A channel's clock is shut off only after a programmable number of consecutive idle cycles. On wake, the clock is restored and a ready handshake is held off for a fixed settle delay. It instantiates one latch-based gate cell per channel and is compiled only under `SCR1_CLKCTRL_EN`.

## Interface
Parameters:
- `CHANNELS`, 4: number of independently gated clock outputs (>=1).
- `IDLE_CNT_W`, 4: width of the idle counter and of `idle_thresh`.
- `WAKE_DLY`, 2: cycles spent in WAKE before `ch_ready` rises (>=1; elaboration error if 0).

Ports:
- `clk` in 1: ungated source clock. All inputs are synchronous to it.
- `rst_n` in 1: asynchronous, active-low reset.
- `test_mode` in 1: forces every `clk_out` bit to follow `clk`. FSMs keep running.
- `ch_busy` in CHANNELS: channel has work this cycle.
- `ch_wake_req` in CHANNELS: explicit wake/keep-alive request.
- `force_on` in CHANNELS: disables gating for the channel while high.
- `idle_thresh` in IDLE_CNT_W: idle-hysteresis threshold, shared by all channels.
- `clk_out` out CHANNELS: gated clocks.
- `ch_gated` out CHANNELS: channel is in GATED.
- `ch_ready` out CHANNELS: channel clock is running and stable.

## Operation
- Activity term per channel i: `act = ch_busy[i] | ch_wake_req[i] | force_on[i]`.
- The FSM is per channel: RUN, COUNT, GATED, WAKE. There is also a per-channel idle counter `cnt` (IDLE_CNT_W bits) and a wake counter (clog2(WAKE_DLY+1) bits).
- RUN: `clk_en=1`, `ready=1`.
  - `!act` → COUNT, `cnt<=0`.
- COUNT: `clk_en=1`, `ready=1`.
  - `act` → RUN.
  - Otherwise, if `cnt >= idle_thresh` → GATED.
  - Otherwise `cnt<=cnt+1`.
  - The clock is therefore gated after `idle_thresh+1` idle cycles in COUNT.
  - Using `>=` makes a threshold lowered mid-count take effect the next cycle.
- GATED: `clk_en=0`, `ready=0`, `gated=1`.
  - `act` → WAKE, wake counter `<=1`.
- WAKE: `clk_en=1`, `ready=0`.
  - When the wake counter equals WAKE_DLY → RUN. Otherwise increment.
  - `act` is ignored in WAKE. A wake cannot be aborted.
- `clk_en` is decoded from the registered state only. There is no combinational path from any input to a gate cell.
- Gate cell: latch transparent while `clk` is low, capturing `clk_en | test_mode`. `clk_out = latch & clk`.
- Reset (async, `rst_n=0`): all channels go to RUN, with both counters at 0.
  - Outputs during and after reset: `ch_ready` all ones, `ch_gated` all zeros, `clk_out` follows `clk`.
  - Reset asserted in GATED or WAKE ungates the channel within the next low phase of `clk`.

## Timing
- The state transition registered at rising edge t takes effect on the `clk_out` high pulse starting at edge t+1. The pulse starting at t is unaffected.
- Gating latency: with `act` last high at the edge before t0, RUN→COUNT occurs at t0 and GATED at t0+`idle_thresh`+1. The pulse at t0+`idle_thresh`+2 is the first suppressed one.
- Wake latency: `act` sampled high in GATED at edge t:
  - WAKE at t, so the pulse at t+1 is delivered.
  - `ch_ready` rises after edge t+WAKE_DLY.
  - `ch_gated` falls after edge t.
- `act` high in the same cycle that COUNT would gate: RUN wins, and no pulse is lost.
- `cnt` never wraps. It stops incrementing at `idle_thresh`, which is at most 2^IDLE_CNT_W−1.
- Channels are fully independent. Simultaneous events on different channels do not interact.
- `test_mode` toggles take effect in the next low phase of `clk`. Status outputs are unaffected.

## Structure
- Package `scr1_cg_pkg`:
  - `type_scr1_cg_state_e` (2-bit enum: RUN, COUNT, GATED, WAKE).
  - Reset-state constant.
  - Clog2 helper for the wake-counter width.
- Sub-module `scr1_cg_cell` (clk, clk_en, test_mode → clk_out): the latch simulation model. It is the only place to swap in the technology ICG cell for synthesis.
- The top level contains a generate loop of CHANNELS FSM+counter slices, each driving one `scr1_cg_cell`.

## Test plan
- Reset release with all `act=0`, `idle_thresh=3`:
  - Each channel goes RUN→COUNT at cycle 1 and GATED at cycle 5.
  - The `clk_out` pulse at cycle 6 is absent.
  - `ch_gated=4'b1111`.
- Channel 2 gated, `ch_busy[2]` pulse for 1 cycle, `WAKE_DLY=2`:
  - `clk_out[2]` resumes on the next pulse.
  - `ch_ready[2]` is high 2 cycles later.
  - Other channels stay gated.
- `idle_thresh=0`: one idle cycle in COUNT then GATED. An `act` pulse arriving in that COUNT cycle returns the channel to RUN with no gated pulse.
- `force_on[0]=1` with `ch_busy=0` for 50 cycles: channel 0 stays in RUN with `ch_ready[0]=1`. The other channels gate.
- `test_mode=1` while all channels are GATED: all `clk_out` follow `clk` from the next pulse, and `ch_gated` stays `4'b1111`.
- `rst_n` asserted mid-WAKE and mid-GATED: outputs immediately take their reset values, and `clk_out` runs from the next low phase.
